num4bit_monitor: RTL
====================

NUM4BIT_MONITOR -- requirements
Module: num4bit_monitor

Interface
REQ-001 Parameter WRAP_W, default 8: width of the wrap counter, legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset: reset=0 forces reset state immediately; reset=1 is normal operation.
REQ-004 q_in  input  4  count output of the upstream num4bit counter, which changes on the falling edge of clk.
REQ-005 arm  input  1  level; 1 enables compare matching, 0 disarms.
REQ-006 thr  input  4  compare threshold; sampled only in IDLE on the cycle arm rises.
REQ-007 q_reg  output  4  registered copy of q_in.
REQ-008 wrap  output  1  one-cycle pulse on count wrap 15->0.
REQ-009 wrap_cnt  output  WRAP_W  saturating count of wraps.
REQ-010 match  output  1  one-cycle pulse when the armed threshold is reached.
REQ-011 state  output  2  FSM state: 00 IDLE, 01 ARMED, 10 HIT, 11 HOLD.
REQ-012 seg  output  7  active-high hex 7-segment decode of q_reg, bit order {g,f,e,d,c,b,a}.

Function
REQ-013 Sampling: q_reg shall capture q_in on every rising edge, giving a half-cycle settle after the falling-edge update; no further synchroniser.
REQ-014 Previous-value register: q_prev shall capture q_reg on every rising edge.
REQ-015 Wrap detect: wrap=1 for exactly one cycle, on the edge after q_reg==0 while q_prev==15. Latency is 2 rising edges from q_in becoming 0.
REQ-016 A jump to 0 from any value other than 15 shall not assert wrap. This covers a counter reset mid-count.
REQ-017 wrap_cnt shall increment by 1 on each wrap pulse.
REQ-018 wrap_cnt shall saturate at 2^WRAP_W-1 and hold there; it never wraps to 0.
REQ-019 Threshold latch: on the IDLE->ARMED transition, thr shall be latched into thr_l; later thr changes are ignored until the next arm.
REQ-020 FSM IDLE: arm=1 goes to ARMED; otherwise stays in IDLE.
REQ-021 FSM ARMED: arm=0 goes to IDLE.
REQ-022 FSM ARMED: arm=1 and q_reg==thr_l goes to HIT.
REQ-023 FSM ARMED: otherwise stays in ARMED.
REQ-024 FSM HIT: lasts exactly one cycle, then goes to HOLD regardless of arm.
REQ-025 FSM HOLD: arm=0 goes to IDLE; otherwise stays in HOLD, so there is no re-match without re-arming.
REQ-026 match shall be registered and equal 1 exactly while state==HIT, so there is one pulse per arm cycle.
REQ-027 Simultaneous arm drop and compare equality in ARMED: disarm has priority; go to IDLE and do not assert match.
REQ-028 Match check: the first comparison occurs on the cycle after entry to ARMED. A q_reg equal to thr_l on the arming edge itself does not match.
REQ-029 wrap and match are independent; both may pulse in the same cycle, for example with thr=0 at a wrap.
REQ-030 seg shall be combinational from q_reg: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.

Reset
REQ-031 While reset=0, the following shall hold asynchronously: q_reg=0, q_prev=0, thr_l=0, wrap=0, wrap_cnt=0, match=0, state=IDLE, and seg=0111111.
REQ-032 Reset release is sampled on the rising edge. The first rising edge with reset=1 shall capture q_in normally.
REQ-033 A reset in any state, including HIT, shall abort to IDLE without a match pulse.
REQ-034 The wrap history shall be cleared by reset, so the first 15->0 transition after reset requires q_prev==15 observed after release.

Verification
REQ-035 Free-running num4bit counter, reset released, 40 cycles -> wrap pulses once per 16 cycles, 2 edges after q_in=0; wrap_cnt=2 after the second wrap.
REQ-036 thr=9, arm raised in IDLE, then thr changed to 3 -> match pulses once while q_reg==9; state goes 01->10->11 and stays 11 with no second match on the next pass through 9.
REQ-037 In ARMED with thr_l=5, arm dropped on the same edge q_reg becomes 5 -> state=IDLE, match stays 0.
REQ-038 Upstream counter reset while q_in=7 -> q_reg goes to 0 and wrap stays 0; wrap_cnt is unchanged.
REQ-039 WRAP_W=2 with 5 wraps -> wrap_cnt reads 1, 2, 3, 3, 3; wrap still pulses each time.
REQ-040 reset=0 asserted between clock edges while state=HIT -> all outputs reach their reset values before the next edge; seg=0111111 and no match pulse follows release.

Source files
------------

// File: rtl/num4bit_monitor.sv
// num4bit_monitor: samples a falling-edge 4-bit counter, detects 15->0 wraps, matches an armed threshold, drives a hex 7-segment display.
module num4bit_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        q_in,
  input  logic              arm,
  input  logic [3:0]        thr,
  output logic [3:0]        q_reg,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              match,
  output logic [1:0]        state,
  output logic [6:0]        seg
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, HIT = 2'b10, HOLD = 2'b11} state_t;
  state_t     r_state;
  logic [3:0] r_q_prev;
  logic [3:0] r_thr_l;
  logic       w_wrap_det;
  logic       w_sat;
  assign w_wrap_det = (q_reg == 4'h0) && (r_q_prev == 4'hF);
  assign w_sat      = &wrap_cnt;
  assign state      = r_state;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg    <= '0;
      r_q_prev <= '0;
      r_thr_l  <= '0;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
      match    <= 1'b0;
      r_state  <= IDLE;
    end else begin
      q_reg    <= q_in;
      r_q_prev <= q_reg;
      wrap     <= w_wrap_det;
      if (w_wrap_det && !w_sat) wrap_cnt <= wrap_cnt + WRAP_W'(1);
      match <= 1'b0;
      case (r_state)
        IDLE: if (arm) begin
          r_state <= ARMED;
          r_thr_l <= thr;
        end
        // disarm wins over a coincident compare hit
        ARMED: if (!arm) r_state <= IDLE;
               else if (q_reg == r_thr_l) begin
                 r_state <= HIT;
                 match   <= 1'b1;
               end
        HIT:   r_state <= HOLD;
        HOLD:  if (!arm) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  always_comb begin
    seg = 7'b0000000;
    case (q_reg)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
  end
endmodule
